// File: rtl/swt_pkg.sv
// Shared types and defaults for the slide-switch debouncer.
package swt_pkg;

  localparam int unsigned SWT_WIDTH           = 16;
  localparam int unsigned DB_CNT_MAX_DEFAULT  = 1_000_000;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    DB_IDLE,
    DB_CONFIRM
  } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: synchroniser chain, stability counter and accept FSM.
// o_acc_c is high in the cycle before o_db takes the new level.
module debounce_bit
  import swt_pkg::*;
#(
  parameter int unsigned CNT_MAX     = DB_CNT_MAX_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_db,
  output logic o_acc_c
);

  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  db_state_t              r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   r_db, w_db_nxt;
  logic                   w_s;

  assign w_s  = r_sync[SYNC_STAGES-1];
  assign o_db = r_db;

  // State, counter, debounced level and synchroniser registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_state <= DB_IDLE;
      r_cnt   <= '0;
      r_db    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
    end
  end

  // Next-state: any return of s to d while confirming restarts the count
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_db_nxt    = r_db;
    o_acc_c     = 1'b0;
    case (r_state)
      DB_IDLE: begin
        if (w_s != r_db) begin
          if (CNT_MAX == 1) begin
            w_db_nxt  = w_s;
            o_acc_c   = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = DB_CONFIRM;
            w_cnt_nxt   = CW'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      DB_CONFIRM: begin
        if (w_s == r_db) begin
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(CNT_MAX - 1)) begin
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
          w_db_nxt    = w_s;
          o_acc_c     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = DB_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/swt_debounce.sv
// Debounces WIDTH raw switches; swt_chg flags any swt_db update.
// Define SWT_EDGE_EN to build the per-bit swt_rise/swt_fall pulse registers.
module swt_debounce
  import swt_pkg::*;
#(
  parameter int unsigned WIDTH       = SWT_WIDTH,
  parameter int unsigned CNT_MAX     = DB_CNT_MAX_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] swt_raw,
  output logic [WIDTH-1:0] swt_db,
  output logic             swt_chg,
  output logic [WIDTH-1:0] swt_rise,
  output logic [WIDTH-1:0] swt_fall
);

  logic [WIDTH-1:0] w_acc;
  logic             r_chg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_bit
    debounce_bit #(
      .CNT_MAX    (CNT_MAX),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (swt_raw[gi]),
      .o_db   (swt_db[gi]),
      .o_acc_c(w_acc[gi])
    );
  end

  // Registered alongside swt_db so the pulse marks the first new-value cycle
  always_ff @(posedge clk) begin
    if (reset) r_chg <= 1'b0;
    else       r_chg <= |w_acc;
  end

  assign swt_chg = r_chg;

`ifdef SWT_EDGE_EN
  logic [WIDTH-1:0] r_rise, r_fall;

  // An accepted bit always flips, so its current level gives the direction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_acc & ~swt_db;
      r_fall <= w_acc & swt_db;
    end
  end

  assign swt_rise = r_rise;
  assign swt_fall = r_fall;
`else
  assign swt_rise = '0;
  assign swt_fall = '0;
`endif

endmodule

// File: tb/tb_swt_debounce.sv
// Scoreboard bench for swt_debounce with CNT_MAX=4, SYNC_STAGES=2.
module tb_swt_debounce;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 6;

  typedef struct {
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] swt_raw;
  logic [W-1:0] swt_db;
  logic         swt_chg;
  logic [W-1:0] swt_rise;
  logic [W-1:0] swt_fall;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  swt_debounce #(.WIDTH(W), .CNT_MAX(4), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .swt_raw (swt_raw),
    .swt_db  (swt_db),
    .swt_chg (swt_chg),
    .swt_rise(swt_rise),
    .swt_fall(swt_fall)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] edge_exp(input logic [W-1:0] v);
`ifdef SWT_EDGE_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges counted from the first edge that samples new stimulus until swt_chg
  task automatic wait_chg(input int max_edges, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < max_edges) begin
      step();
      n++;
      if (swt_chg === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic push_exp(input logic [W-1:0] db, input logic [W-1:0] rise,
                          input logic [W-1:0] fall);
    exp_t e;
    e.db   = db;
    e.rise = edge_exp(rise);
    e.fall = edge_exp(fall);
    e.lat  = LAT;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    int   n;
    bit   seen;
    exp_t e;
    reset   = 1'b1;
    swt_raw = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (swt_db !== '0 || swt_chg !== 1'b0 || swt_rise !== '0 || swt_fall !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: db=%h chg=%b rise=%h fall=%h required all 0",
                 i, swt_db, swt_chg, swt_rise, swt_fall);
      end
    end
    push_exp(16'hFFFF, 16'hFFFF, 16'h0000);
    reset = 1'b0;
    wait_chg(20, n, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != e.lat) begin
      errors++;
      $display("FAIL reset_release_latency: edges=%0d seen=%0b required %0d", n, seen, e.lat);
    end
    checks++;
    if (swt_db !== e.db || swt_rise !== e.rise || swt_fall !== e.fall) begin
      errors++;
      $display("FAIL reset_release_value: db=%h rise=%h fall=%h required %h/%h/%h",
               swt_db, swt_rise, swt_fall, e.db, e.rise, e.fall);
    end
    step();
    checks++;
    if (swt_chg !== 1'b0 || swt_rise !== '0 || swt_db !== e.db) begin
      errors++;
      $display("FAIL reset_release_pulse: chg=%b rise=%h db=%h required 0/0/%h",
               swt_chg, swt_rise, swt_db, e.db);
    end
  endtask

  task automatic test_fall_all();
    int   n;
    bit   seen;
    exp_t e;
    push_exp(16'h0000, 16'h0000, 16'hFFFF);
    swt_raw = 16'h0000;
    wait_chg(20, n, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != e.lat) begin
      errors++;
      $display("FAIL fall_latency: edges=%0d seen=%0b required %0d", n, seen, e.lat);
    end
    checks++;
    if (swt_db !== e.db || swt_rise !== e.rise || swt_fall !== e.fall) begin
      errors++;
      $display("FAIL fall_value: db=%h rise=%h fall=%h required %h/%h/%h",
               swt_db, swt_rise, swt_fall, e.db, e.rise, e.fall);
    end
    step();
    checks++;
    if (swt_chg !== 1'b0 || swt_fall !== '0) begin
      errors++;
      $display("FAIL fall_pulse: chg=%b fall=%h required 0/0", swt_chg, swt_fall);
    end
  endtask

  task automatic test_clean_step();
    int   n;
    bit   seen;
    exp_t e;
    push_exp(16'h0001, 16'h0001, 16'h0000);
    swt_raw = 16'h0001;
    wait_chg(20, n, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != e.lat) begin
      errors++;
      $display("FAIL step_latency: edges=%0d seen=%0b required %0d", n, seen, e.lat);
    end
    checks++;
    if (swt_db !== e.db || swt_rise !== e.rise || swt_fall !== e.fall) begin
      errors++;
      $display("FAIL step_value: db=%h rise=%h fall=%h required %h/%h/%h",
               swt_db, swt_rise, swt_fall, e.db, e.rise, e.fall);
    end
    step();
    checks++;
    if (swt_chg !== 1'b0 || swt_rise !== '0 || swt_db !== e.db) begin
      errors++;
      $display("FAIL step_pulse: chg=%b rise=%h db=%h required 0/0/%h",
               swt_chg, swt_rise, swt_db, e.db);
    end
  endtask

  task automatic test_bounce();
    logic pat [0:19];
    for (int i = 0; i < 20; i++) pat[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pat[i]     = 1'b1;
      pat[i + 4] = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      swt_raw[5] = pat[i];
      step();
      checks++;
      if (swt_chg !== 1'b0 || swt_db !== 16'h0001) begin
        errors++;
        $display("FAIL bounce cyc%0d: chg=%b db=%h required 0/0001", i, swt_chg, swt_db);
      end
    end
  endtask

  task automatic test_simultaneous();
    int   n;
    bit   seen;
    exp_t e;
    push_exp(16'h0000, 16'h0000, 16'h0001);
    push_exp(16'hA5A5, 16'hA5A5, 16'h0000);
    swt_raw = 16'h0000;
    wait_chg(20, n, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != e.lat || swt_db !== e.db || swt_fall !== e.fall) begin
      errors++;
      $display("FAIL simul_clear: edges=%0d seen=%0b db=%h fall=%h required %0d/1/%h/%h",
               n, seen, swt_db, swt_fall, e.lat, e.db, e.fall);
    end
    step();
    swt_raw = 16'hA5A5;
    wait_chg(20, n, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != e.lat) begin
      errors++;
      $display("FAIL simul_latency: edges=%0d seen=%0b required %0d", n, seen, e.lat);
    end
    checks++;
    if (swt_db !== e.db || swt_rise !== e.rise || swt_fall !== e.fall) begin
      errors++;
      $display("FAIL simul_value: db=%h rise=%h fall=%h required %h/%h/%h",
               swt_db, swt_rise, swt_fall, e.db, e.rise, e.fall);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (swt_chg !== 1'b0 || swt_rise !== '0 || swt_db !== e.db) begin
        errors++;
        $display("FAIL simul_single_pulse cyc%0d: chg=%b rise=%h db=%h required 0/0/%h",
                 i, swt_chg, swt_rise, swt_db, e.db);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    bit   seen;
    exp_t e;
    push_exp(16'h0000, 16'h0000, 16'hA5A5);
    swt_raw = 16'h0000;
    wait_chg(20, n, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != e.lat || swt_db !== e.db || swt_fall !== e.fall) begin
      errors++;
      $display("FAIL mid_clear: edges=%0d seen=%0b db=%h fall=%h required %0d/1/%h/%h",
               n, seen, swt_db, swt_fall, e.lat, e.db, e.fall);
    end
    step();
    swt_raw = 16'h0008;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    checks++;
    if (swt_db !== '0 || swt_chg !== 1'b0 || swt_rise !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: db=%h chg=%b rise=%h required 0/0/0",
               swt_db, swt_chg, swt_rise);
    end
    push_exp(16'h0008, 16'h0008, 16'h0000);
    reset = 1'b0;
    wait_chg(20, n, seen);
    e = sb_q.pop_front();
    checks++;
    if (!seen || n != e.lat) begin
      errors++;
      $display("FAIL mid_latency: edges=%0d seen=%0b required %0d", n, seen, e.lat);
    end
    checks++;
    if (swt_db !== e.db || swt_rise !== e.rise || swt_fall !== e.fall) begin
      errors++;
      $display("FAIL mid_value: db=%h rise=%h fall=%h required %h/%h/%h",
               swt_db, swt_rise, swt_fall, e.db, e.rise, e.fall);
    end
  endtask

  initial begin
    reset   = 1'b1;
    swt_raw = '0;
    test_reset();
    test_fall_all();
    test_clean_step();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
